dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port between the core's load/store path and a debug/loader port. It sits between the core's ALU-address/store-data wires and the data memory: it muxes address, write data and write enable onto the memory, and returns read data to each side. It stalls the core when the core loses arbitration. Fairness is round-robin, with optional bounded debug bursts.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_fsm.sv | 103 ++++++++++
 rtl/dmem_arbiter.sv | 78 +++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ARB_ADDR_W    = 32;
    localparam int unsigned ARB_DATA_W    = 32;
    localparam int unsigned ARB_MAX_BURST = 4;

    typedef enum logic [1:0] {
        S_CORE_PRI  = 2'd0,
        S_DBG_PRI   = 2'd1,
        S_DBG_BURST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Round-robin grant decode between core and debug requesters.
// Optional bounded debug bursts under contention: define ARB_DBG_BURST_EN.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic core_req,
    input  logic dbg_req,
    output logic core_gnt,
    output logic dbg_gnt
);

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("dmem_arb_fsm: MAX_BURST must be >= 1");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;

`ifdef ARB_DBG_BURST_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    // Count value held while the final grant of a burst is being issued.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CORE_PRI;
`ifdef ARB_DBG_BURST_EN
            r_burst_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef ARB_DBG_BURST_EN
            r_burst_cnt <= w_burst_cnt_nxt;
`endif
        end
    end

    always_comb begin
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        w_state_nxt = r_state;
`ifdef ARB_DBG_BURST_EN
        w_burst_cnt_nxt = r_burst_cnt;
`endif
        if (!rst) begin
            if (core_req && dbg_req) begin
                case (r_state)
                    S_DBG_PRI: begin
                        dbg_gnt = 1'b1;
`ifdef ARB_DBG_BURST_EN
                        if (BURST_LAST == '0) begin
                            w_state_nxt     = S_CORE_PRI;
                            w_burst_cnt_nxt = '0;
                        end else begin
                            w_state_nxt     = S_DBG_BURST;
                            w_burst_cnt_nxt = CNT_W'(1);
                        end
`else
                        w_state_nxt = S_CORE_PRI;
`endif
                    end
`ifdef ARB_DBG_BURST_EN
                    S_DBG_BURST: begin
                        dbg_gnt = 1'b1;
                        if (r_burst_cnt >= BURST_LAST) begin
                            w_state_nxt     = S_CORE_PRI;
                            w_burst_cnt_nxt = '0;
                        end else begin
                            w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        core_gnt    = 1'b1;
                        w_state_nxt = S_DBG_PRI;
`ifdef ARB_DBG_BURST_EN
                        w_burst_cnt_nxt = '0;
`endif
                    end
                endcase
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
`ifdef ARB_DBG_BURST_EN
                // A lone core access or idle cycle ends the burst but keeps debug next in line.
                if ((r_state == S_DBG_BURST) && !dbg_req) begin
                    w_state_nxt     = S_DBG_PRI;
                    w_burst_cnt_nxt = '0;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core load/store path and the debug port.
// Optional bounded debug bursts: define ARB_DBG_BURST_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ARB_ADDR_W,
    parameter int unsigned DATA_W    = ARB_DATA_W,
    parameter int unsigned MAX_BURST = ARB_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    logic              w_core_gnt;
    logic              w_dbg_gnt;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_dbg_rvalid;

    dmem_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .core_req (core_req),
        .dbg_req  (dbg_req),
        .core_gnt (w_core_gnt),
        .dbg_gnt  (w_dbg_gnt)
    );

    // The core side is the idle default, so its store only lands when actually granted.
    always_comb begin
        if (w_dbg_gnt) begin
            mem_a  = dbg_addr;
            mem_wd = dbg_wdata;
            mem_we = dbg_we;
        end else begin
            mem_a  = core_addr;
            mem_wd = core_wdata;
            mem_we = w_core_gnt & core_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_rdata  <= '0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
            if (w_dbg_gnt && !dbg_we) begin
                r_dbg_rdata <= mem_rd;
            end
        end
    end

    assign core_rdata = mem_rd;
    assign core_stall = core_req & ~w_core_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign dbg_rdata  = r_dbg_rdata;
    assign dbg_rvalid = r_dbg_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a turn-taking reference model.
// Builds with or without ARB_DBG_BURST_EN.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef ARB_DBG_BURST_EN
    localparam int unsigned MB = 4;
`else
    localparam int unsigned MB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Word-addressed 16-entry memory behind the arbiter.
    logic [DW-1:0] bmem [16];
    assign mem_rd = bmem[mem_a[5:2]];
    always @(posedge clk) begin
        if (mem_we) bmem[mem_a[5:2]] <= mem_wd;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: debug "owes a turn" flag plus length of its current contention streak.
    logic [DW-1:0] mmem [16];
    bit            m_pri_dbg = 1'b0;
    int unsigned   m_streak = 0;
    bit            exp_rvalid = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    bit            regs_known = 1'b0;
    bit            last_dbg_gnt = 1'b0;
    bit            last_stall = 1'b0;
    bit            obs_dbg_gnt, obs_stall;

    task automatic run_cycle();
        bit            both, eg_core, eg_dbg, e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        #1;
        both    = core_req && dbg_req;
        eg_core = 1'b0;
        eg_dbg  = 1'b0;
        if (!rst) begin
            if (both) begin
                eg_dbg  = m_pri_dbg;
                eg_core = !m_pri_dbg;
            end else begin
                eg_core = core_req;
                eg_dbg  = dbg_req;
            end
        end
        e_a  = eg_dbg ? dbg_addr : core_addr;
        e_wd = eg_dbg ? dbg_wdata : core_wdata;
        e_we = eg_dbg ? dbg_we : (eg_core && core_we);

        check_eq("dbg_gnt", dbg_gnt, eg_dbg);
        check_eq("core_stall", core_stall, core_req && !eg_core);
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_a", mem_a, e_a);
        check_eq("mem_wd", mem_wd, e_wd);
        check_eq("core_rdata", core_rdata, mmem[e_a[5:2]]);
        if (regs_known) begin
            check_eq("dbg_rvalid", dbg_rvalid, exp_rvalid);
            check_eq("dbg_rdata", dbg_rdata, exp_rdata);
        end
        obs_dbg_gnt  = dbg_gnt;
        obs_stall    = core_stall;
        last_dbg_gnt = eg_dbg;
        last_stall   = core_req && !eg_core;

        @(posedge clk);
        if (rst) begin
            m_pri_dbg  = 1'b0;
            m_streak   = 0;
            exp_rvalid = 1'b0;
            exp_rdata  = '0;
            regs_known = 1'b1;
        end else begin
            exp_rvalid = eg_dbg && !dbg_we;
            if (eg_dbg && !dbg_we) exp_rdata = mmem[dbg_addr[5:2]];
            if (e_we) mmem[e_a[5:2]] = e_wd;
            if (both) begin
                if (eg_dbg) begin
                    m_streak++;
                    if (m_streak >= MB) begin
                        m_pri_dbg = 1'b0;
                        m_streak  = 0;
                    end
                end else begin
                    m_pri_dbg = 1'b1;
                end
            end else if (!dbg_req) begin
                m_streak = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_core(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_dbg(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned   run, max_run;
        logic [DW-1:0] saved;

        for (int i = 0; i < 16; i++) begin
            bmem[i] = $urandom;
            mmem[i] = bmem[i];
        end
        bmem[8] = 32'h1234_5678;
        mmem[8] = 32'h1234_5678;

        rst = 1'b1;
        set_core(1'b1, 1'b1, 32'h3C, 32'hBAD0_BAD0);
        set_dbg(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        run_cycle();
        run_cycle();
        check_eq("rst_rvalid", dbg_rvalid, 1'b0);
        check_eq("rst_rdata", dbg_rdata, '0);

        // Core-only store.
        rst = 1'b0;
        set_core(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        #1;
        check_eq("core_only_we", mem_we, 1'b1);
        check_eq("core_only_a", mem_a, 32'h10);
        check_eq("core_only_stall", core_stall, 1'b0);
        check_eq("core_only_dgnt", dbg_gnt, 1'b0);
        run_cycle();

        // Debug-only read.
        set_core(1'b0, 1'b0, '0, '0);
        set_dbg(1'b1, 1'b0, 32'h20, '0);
        run_cycle();
        check_eq("dbg_read_gnt", obs_dbg_gnt, 1'b1);
        set_dbg(1'b0, 1'b0, '0, '0);
        check_eq("dbg_read_rvalid", dbg_rvalid, 1'b1);
        check_eq("dbg_read_data", dbg_rdata, 32'h1234_5678);
        run_cycle();
        check_eq("dbg_read_rvalid_off", dbg_rvalid, 1'b0);

        // Continuous contention from reset.
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        set_core(1'b1, 1'b0, 32'h4, '0);
        set_dbg(1'b1, 1'b0, 32'h8, '0);
        run = 0;
        max_run = 0;
        for (int k = 0; k < 3 * (MB + 1); k++) begin
            run_cycle();
            check_eq("contend_seq", obs_dbg_gnt, (k % (MB + 1)) != 0);
            run = obs_stall ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check_eq("stall_run_max", max_run, MB);

        // Abort: debug write loses one cycle, then drops its request.
        rst = 1'b1;
        set_dbg(1'b0, 1'b0, '0, '0);
        run_cycle();
        rst = 1'b0;
        saved = bmem[12];
        set_core(1'b1, 1'b0, 32'h4, '0);
        set_dbg(1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5);
        run_cycle();
        check_eq("abort_lost", obs_dbg_gnt, 1'b0);
        set_dbg(1'b0, 1'b1, 32'h30, 32'hA5A5_A5A5);
        run_cycle();
        run_cycle();
        check_eq("abort_mem", bmem[12], saved);
        check_eq("abort_rvalid", dbg_rvalid, 1'b0);

        // Reset right after a granted debug read.
        set_core(1'b0, 1'b0, '0, '0);
        set_dbg(1'b1, 1'b0, 32'h20, '0);
        run_cycle();
        rst = 1'b1;
        set_dbg(1'b0, 1'b0, '0, '0);
        set_core(1'b1, 1'b1, 32'h14, 32'h5555_AAAA);
        #1;
        check_eq("mid_rst_we", mem_we, 1'b0);
        run_cycle();
        check_eq("mid_rst_rvalid", dbg_rvalid, 1'b0);
        check_eq("mid_rst_rdata", dbg_rdata, '0);
        rst = 1'b0;
        set_core(1'b1, 1'b0, 32'h14, '0);
        set_dbg(1'b1, 1'b0, 32'h18, '0);
        #1;
        check_eq("post_rst_core_wins", core_stall, 1'b0);
        run_cycle();

        // Randomized traffic with held debug requests, aborts and occasional resets.
        set_dbg(1'b0, 1'b0, '0, '0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!last_stall) begin
                set_core($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                         AW'($urandom_range(0, 15) << 2), $urandom);
            end
            if (dbg_req && !last_dbg_gnt) begin
                if ($urandom_range(0, 9) == 0) dbg_req = 1'b0;
            end else begin
                set_dbg($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                        AW'($urandom_range(0, 15) << 2), $urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
